multdiv_iter: RTL

//  Iterative signed 32-bit multiply/divide unit for the processor execute stage.
//  A one-cycle ctrl_MULT or ctrl_DIV pulse starts an operation. The result is

---
 rtl/multdiv_iter.sv | 80 ++++++++
 1 files changed

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply (radix-2 Booth) / divide (restoring), WIDTH cycles per op.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic op_div, q_m1, neg, dz, ovf, fits, mul_exc, start, last;
  logic [CW-1:0] count;
  logic [WIDTH:0] acc, acc_n, booth_sum, shifted, trial;
  logic [WIDTH-1:0] q, q_n, m, abs_a, abs_b;
  logic [2*WIDTH-1:0] product;
  assign start = ctrl_MULT | ctrl_DIV;
  assign last = count == CW'(WIDTH - 1);
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  // acc is one bit wider than WIDTH so Booth steps with a most-negative multiplicand cannot wrap
  assign booth_sum = ({q[0], q_m1} == 2'b01) ? acc + {m[WIDTH-1], m} :
                     ({q[0], q_m1} == 2'b10) ? acc - {m[WIDTH-1], m} : acc;
  assign shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign trial = shifted - {1'b0, m};
  assign fits = !trial[WIDTH];
  assign acc_n = op_div ? (fits ? trial : shifted) : {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign q_n = op_div ? {q[WIDTH-2:0], fits} : {booth_sum[0], q[WIDTH-1:1]};
  assign product = {acc_n[WIDTH-1:0], q_n};
  assign mul_exc = !(&product[2*WIDTH-1:WIDTH-1]) && |product[2*WIDTH-1:WIDTH-1];
  assign data_resultRDY = state == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    if (start) state_n = RUN;
    else if (state == RUN) state_n = last ? DONE : RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      op_div <= 1'b0;
      acc <= '0;
      q <= '0;
      q_m1 <= 1'b0;
      m <= '0;
      neg <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
      data_result <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      count <= '0;
      op_div <= !ctrl_MULT;
      acc <= '0;
      q_m1 <= 1'b0;
      q <= ctrl_MULT ? data_operandB : abs_a;
      m <= ctrl_MULT ? data_operandA : abs_b;
      neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz <= data_operandB == '0;
      ovf <= data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && data_operandB == '1;
    end else if (state == RUN) begin
      count <= count + 1'b1;
      acc <= acc_n;
      q <= q_n;
      q_m1 <= q[0];
      if (last) begin
        data_result <= !op_div ? product[WIDTH-1:0] : dz ? '0 : neg ? -q_n : q_n;
        data_exception <= op_div ? (dz | ovf) : mul_exc;
      end
    end
  end
endmodule
